// File: rtl/return_addr_stack_ckpt.sv
// Speculation-safe return address stack with an in-order checkpoint queue for misprediction recovery.
// Optional RAS_STATS_EN adds saturating overflow/underflow/restore event counters.
module return_addr_stack_ckpt #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int NUM_CKPT   = 4,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = $clog2(NUM_CKPT)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [ADDR_WIDTH-1:0] push_addr_i,
  input  logic                  pop_i,
  output logic [ADDR_WIDTH-1:0] top_addr_o,
  output logic                  top_valid_o,
  output logic [PW:0]           count_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  input  logic                  ckpt_alloc_i,
  output logic                  ckpt_ready_o,
  output logic [CW-1:0]         ckpt_id_o,
  input  logic                  ckpt_release_i,
  input  logic                  restore_i,
  input  logic [CW-1:0]         restore_id_i
`ifdef RAS_STATS_EN
  ,
  output logic [31:0]           stat_ovf_o,
  output logic [31:0]           stat_unf_o,
  output logic [31:0]           stat_restore_o
`endif
);

  logic [ADDR_WIDTH-1:0] mem    [DEPTH];
  logic [PW-1:0]         ck_ptr [NUM_CKPT];
  logic [PW:0]           ck_cnt [NUM_CKPT];
  logic [ADDR_WIDTH-1:0] ck_top [NUM_CKPT];

  logic [PW-1:0] ptr;
  logic [PW:0]   count;
  logic [CW-1:0] head, tail;
  logic [CW:0]   occ;

  logic          full, empty;
  logic          do_push, do_pop, do_tail;
  logic          alloc_ok, rel_ok, restore_ok, restore_rel;
  logic [CW-1:0] restore_off;
  logic [PW-1:0] ptr_inc, ptr_dec;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  always_comb begin
    full         = (count == (PW+1)'(DEPTH));
    empty        = (count == '0);
    ptr_inc      = ptr + PW'(1);
    ptr_dec      = ptr - PW'(1);
    ckpt_ready_o = (occ < (CW+1)'(NUM_CKPT));
    // Restore wins the cycle outright, legal or not; stack ops and alloc are dropped.
    do_push      = push_i && !pop_i && !restore_i;
    do_pop       = pop_i && !push_i && !restore_i;
    do_tail      = push_i && pop_i && !restore_i;
    alloc_ok     = ckpt_alloc_i && ckpt_ready_o && !restore_i;
    rel_ok       = ckpt_release_i && (occ != '0) && !restore_i;
    restore_off  = restore_id_i - head;
    restore_ok   = restore_i && ({1'b0, restore_off} < occ);
    restore_rel  = restore_ok && ckpt_release_i && (restore_id_i != head);
  end

  assign top_addr_o  = mem[ptr];
  assign top_valid_o = !empty;
  assign count_o     = count;
  assign ckpt_id_o   = tail;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr         <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      occ         <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      overflow_o  <= do_push && full;
      underflow_o <= do_pop && empty;
      if (restore_i) begin
        if (restore_ok) begin
          ptr   <= ck_ptr[restore_id_i];
          count <= ck_cnt[restore_id_i];
          tail  <= restore_id_i;
          if (restore_rel) begin
            head <= head + CW'(1);
            occ  <= {1'b0, restore_off} - (CW+1)'(1);
          end else begin
            occ  <= {1'b0, restore_off};
          end
        end
      end else begin
        if (do_push) begin
          ptr <= ptr_inc;
          if (!full) count <= count + (PW+1)'(1);
        end else if (do_pop && !empty) begin
          ptr   <= ptr_dec;
          count <= count - (PW+1)'(1);
        end
        if (alloc_ok) tail <= tail + CW'(1);
        if (rel_ok)   head <= head + CW'(1);
        occ <= occ + (CW+1)'(alloc_ok) - (CW+1)'(rel_ok);
      end
    end
  end

  // Payload storage is never cleared; only its write enables are qualified by reset.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (restore_ok)   mem[ck_ptr[restore_id_i]] <= ck_top[restore_id_i];
      else if (do_push) mem[ptr_inc] <= push_addr_i;
      else if (do_tail) mem[ptr] <= push_addr_i;
      if (alloc_ok) begin
        ck_ptr[tail] <= ptr;
        ck_cnt[tail] <= count;
        ck_top[tail] <= mem[ptr];
      end
    end
  end

`ifdef RAS_STATS_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stat_ovf_o     <= '0;
      stat_unf_o     <= '0;
      stat_restore_o <= '0;
    end else begin
      if (do_push && full) stat_ovf_o     <= sat_inc(stat_ovf_o);
      if (do_pop && empty) stat_unf_o     <= sat_inc(stat_unf_o);
      if (restore_ok)      stat_restore_o <= sat_inc(stat_restore_o);
    end
  end
`endif

endmodule

// File: tb/tb_return_addr_stack_ckpt.sv
// Self-checking bench for return_addr_stack_ckpt: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_return_addr_stack_ckpt;
  localparam int AW = 32;
  localparam int D  = 16;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          push = 1'b0, pop = 1'b0, alloc = 1'b0, rel = 1'b0, rest = 1'b0;
  logic [AW-1:0] push_addr = '0;
  logic [1:0]    rest_id = '0;
  logic [AW-1:0] top_addr;
  logic          top_valid, ovf, unf, ready;
  logic [4:0]    cnt;
  logic [1:0]    ck_id;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  return_addr_stack_ckpt #(.ADDR_WIDTH(AW), .DEPTH(D), .NUM_CKPT(N)) dut (
    .clk_i(clk), .rst_ni(rst_n), .push_i(push), .push_addr_i(push_addr), .pop_i(pop),
    .top_addr_o(top_addr), .top_valid_o(top_valid), .count_o(cnt),
    .overflow_o(ovf), .underflow_o(unf), .ckpt_alloc_i(alloc), .ckpt_ready_o(ready),
    .ckpt_id_o(ck_id), .ckpt_release_i(rel), .restore_i(rest), .restore_id_i(rest_id)
  );

  task automatic cyc(input logic r_n, input logic p, input logic [AW-1:0] a, input logic po,
                     input logic al, input logic rl, input logic rs, input logic [1:0] rid);
    rst_n = r_n; push = p; push_addr = a; pop = po; alloc = al; rel = rl; rest = rs; rest_id = rid;
    @(posedge clk);
    #1;
    rst_n = 1'b1; push = 1'b0; pop = 1'b0; alloc = 1'b0; rel = 1'b0; rest = 1'b0;
  endtask

  task automatic do_push(input logic [AW-1:0] a); cyc(1, 1, a, 0, 0, 0, 0, 0); endtask
  task automatic do_pop();                        cyc(1, 0, 0, 1, 0, 0, 0, 0); endtask
  task automatic do_alloc();                      cyc(1, 0, 0, 0, 1, 0, 0, 0); endtask
  task automatic do_reset();                      cyc(0, 0, 0, 0, 0, 0, 0, 0); endtask

  task automatic test_reset();
    push = 1'b1; pop = 1'b0; push_addr = 32'hDEAD; alloc = 1'b1;
    rst_n = 1'b0; @(posedge clk); #1;
    rst_n = 1'b1; push = 1'b0; alloc = 1'b0;
    compared++; if (cnt !== 5'd0) begin mismatched++; $display("FAIL reset_count got %0d want 0", cnt); end
    compared++; if (top_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b want 0", top_valid); end
    compared++; if (ovf !== 1'b0 || unf !== 1'b0) begin mismatched++; $display("FAIL reset_pulses got %b%b want 00", ovf, unf); end
    compared++; if (ready !== 1'b1 || ck_id !== 2'd0) begin mismatched++; $display("FAIL reset_ckpt got ready=%b id=%0d want 1/0", ready, ck_id); end
  endtask

  task automatic test_basic();
    do_reset();
    do_push(32'h2004); do_push(32'h3104);
    compared++; if (top_addr !== 32'h3104 || cnt !== 5'd2) begin mismatched++; $display("FAIL basic_push got top=%h cnt=%0d want 3104/2", top_addr, cnt); end
    do_pop();
    compared++; if (top_addr !== 32'h2004 || cnt !== 5'd1) begin mismatched++; $display("FAIL basic_pop1 got top=%h cnt=%0d want 2004/1", top_addr, cnt); end
    do_pop();
    compared++; if (top_valid !== 1'b0 || unf !== 1'b0) begin mismatched++; $display("FAIL basic_pop2 got valid=%b unf=%b want 0/0", top_valid, unf); end
    do_pop();
    compared++; if (unf !== 1'b1 || cnt !== 5'd0) begin mismatched++; $display("FAIL basic_underflow got unf=%b cnt=%0d want 1/0", unf, cnt); end
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    compared++; if (unf !== 1'b0) begin mismatched++; $display("FAIL basic_unf_pulse got %b want 0", unf); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 16; k++) do_push(32'h1000 + 32'(4 * k));
    compared++; if (ovf !== 1'b0 || cnt !== 5'd16) begin mismatched++; $display("FAIL ovf_16th got ovf=%b cnt=%0d want 0/16", ovf, cnt); end
    do_push(32'h1040);
    compared++; if (ovf !== 1'b1 || cnt !== 5'd16) begin mismatched++; $display("FAIL ovf_17th got ovf=%b cnt=%0d want 1/16", ovf, cnt); end
    for (int i = 0; i < 16; i++) begin
      compared++;
      if (top_addr !== 32'h1040 - 32'(4 * i)) begin
        mismatched++; $display("FAIL ovf_pop%0d got %h want %h", i, top_addr, 32'h1040 - 32'(4 * i));
      end
      do_pop();
    end
    compared++; if (cnt !== 5'd0 || ovf !== 1'b0) begin mismatched++; $display("FAIL ovf_drained got cnt=%0d ovf=%b want 0/0", cnt, ovf); end
  endtask

  task automatic test_restore_repair();
    do_reset();
    do_push(32'h2004);
    compared++; if (ck_id !== 2'd0) begin mismatched++; $display("FAIL repair_id got %0d want 0", ck_id); end
    do_alloc(); do_pop(); do_push(32'h9999);
    compared++; if (top_addr !== 32'h9999) begin mismatched++; $display("FAIL repair_corrupt got %h want 9999", top_addr); end
    cyc(1, 0, 0, 0, 0, 0, 1, 2'd0);
    compared++; if (top_addr !== 32'h2004 || cnt !== 5'd1) begin mismatched++; $display("FAIL repair_restore got top=%h cnt=%0d want 2004/1", top_addr, cnt); end
    compared++; if (ready !== 1'b1 || ck_id !== 2'd0) begin mismatched++; $display("FAIL repair_queue got ready=%b id=%0d want 1/0", ready, ck_id); end
  endtask

  task automatic test_ckpt_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      compared++; if (ck_id !== 2'(i)) begin mismatched++; $display("FAIL full_id%0d got %0d want %0d", i, ck_id, i); end
      do_alloc();
    end
    compared++; if (ready !== 1'b0) begin mismatched++; $display("FAIL full_ready got %b want 0", ready); end
    do_alloc();
    compared++; if (ready !== 1'b0 || ck_id !== 2'd0) begin mismatched++; $display("FAIL full_5th got ready=%b id=%0d want 0/0", ready, ck_id); end
    cyc(1, 0, 0, 0, 1, 1, 0, 0);
    compared++; if (ready !== 1'b1 || ck_id !== 2'd0) begin mismatched++; $display("FAIL full_release got ready=%b id=%0d want 1/0", ready, ck_id); end
  endtask

  task automatic test_nested_restore();
    do_reset();
    do_push(32'h3004); do_alloc(); do_push(32'h3104); do_alloc(); do_push(32'h3204);
    cyc(1, 0, 0, 0, 0, 0, 1, 2'd1);
    compared++; if (top_addr !== 32'h3104 || cnt !== 5'd2 || ck_id !== 2'd1) begin mismatched++; $display("FAIL nested_id1 got top=%h cnt=%0d tail=%0d want 3104/2/1", top_addr, cnt, ck_id); end
    cyc(1, 0, 0, 0, 0, 0, 1, 2'd0);
    compared++; if (top_addr !== 32'h3004 || cnt !== 5'd1 || ck_id !== 2'd0 || ready !== 1'b1) begin mismatched++; $display("FAIL nested_id0 got top=%h cnt=%0d tail=%0d rdy=%b want 3004/1/0/1", top_addr, cnt, ck_id, ready); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    do_push(32'h1); do_push(32'h2); do_push(32'h5000);
    cyc(1, 1, 32'hA000, 1, 0, 0, 0, 0);
    compared++; if (top_addr !== 32'hA000 || cnt !== 5'd3 || ovf !== 1'b0 || unf !== 1'b0) begin mismatched++; $display("FAIL tailcall got top=%h cnt=%0d ovf=%b unf=%b want A000/3/0/0", top_addr, cnt, ovf, unf); end
    do_alloc();
    cyc(1, 1, 32'hBBBB, 0, 0, 0, 1, 2'd0);
    compared++; if (top_addr !== 32'hA000 || cnt !== 5'd3) begin mismatched++; $display("FAIL restore_push got top=%h cnt=%0d want A000/3", top_addr, cnt); end
    do_alloc(); do_alloc();
    cyc(1, 0, 0, 0, 0, 1, 1, 2'd1);
    compared++; if (ck_id !== 2'd1 || ready !== 1'b1) begin mismatched++; $display("FAIL restore_release got id=%0d ready=%b want 1/1", ck_id, ready); end
    do_alloc(); do_alloc(); do_alloc();
    compared++; if (ready !== 1'b1) begin mismatched++; $display("FAIL restore_release_occ3 got ready=%b want 1", ready); end
    do_alloc();
    compared++; if (ready !== 1'b0) begin mismatched++; $display("FAIL restore_release_occ4 got ready=%b want 0", ready); end
  endtask

  typedef struct { int p; int c; logic [AW-1:0] t; } ck_t;

  task automatic test_random();
    logic [AW-1:0] mm [D];
    ck_t q[$];
    ck_t snap;
    int mp, mc, mh, idx;
    logic e_ovf, e_unf, r_n, p, po, al, rl, rs;
    logic [AW-1:0] a;
    logic [1:0] rid;
    int errs = 0;
    do_reset();
    mp = 0; mc = 0; mh = 0;
    for (int n = 0; n < 3000; n++) begin
      r_n = ($urandom_range(0, 99) != 0);
      p = ($urandom_range(0, 9) < 4); po = ($urandom_range(0, 9) < 4);
      al = ($urandom_range(0, 9) < 3); rl = ($urandom_range(0, 9) < 2);
      rs = (q.size() != 0) && ($urandom_range(0, 19) == 0);
      a = $urandom;
      idx = (q.size() != 0) ? $urandom_range(0, q.size() - 1) : 0;
      rid = 2'((mh + idx) % N);
      e_ovf = 1'b0; e_unf = 1'b0;
      if (!r_n) begin
        mp = 0; mc = 0; mh = 0; q.delete();
      end else if (rs) begin
        mp = q[idx].p; mc = q[idx].c; mm[mp] = q[idx].t;
        while (q.size() > idx) void'(q.pop_back());
        if (rl && idx != 0) begin void'(q.pop_front()); mh = (mh + 1) % N; end
      end else begin
        snap.p = mp; snap.c = mc; snap.t = mm[mp];
        if (p && po) mm[mp] = a;
        else if (p) begin
          e_ovf = (mc == D); mp = (mp + 1) % D; mm[mp] = a; if (mc < D) mc++;
        end else if (po) begin
          if (mc == 0) e_unf = 1'b1; else begin mp = (mp + D - 1) % D; mc--; end
        end
        if (al && q.size() < N) begin
          if (rl && q.size() != 0) begin void'(q.pop_front()); mh = (mh + 1) % N; end
          q.push_back(snap);
        end else if (rl && q.size() != 0) begin
          void'(q.pop_front()); mh = (mh + 1) % N;
        end
      end
      cyc(r_n, p, a, po, al, rl, rs, rid);
      compared++;
      if (cnt !== 5'(mc) || top_valid !== (mc != 0) || ovf !== e_ovf || unf !== e_unf ||
          ready !== (q.size() < N) || ck_id !== 2'((mh + q.size()) % N) ||
          (mc != 0 && top_addr !== mm[mp])) begin
        mismatched++; errs++;
        if (errs <= 10)
          $display("FAIL random_cyc%0d got cnt=%0d top=%h ovf=%b unf=%b rdy=%b id=%0d want cnt=%0d top=%h ovf=%b unf=%b rdy=%b id=%0d",
                   n, cnt, top_addr, ovf, unf, ready, ck_id, mc, mm[mp], e_ovf, e_unf, q.size() < N, (mh + q.size()) % N);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_restore_repair();
    test_ckpt_full();
    test_nested_restore();
    test_same_cycle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
